// File: rtl/keypad_num_entry.sv
// keypad_num_entry: 4x4 keypad scanner with press/release debounce and decimal-entry accumulator
//   clk         system clock
//   rst_n       synchronous active-low reset
//   key_col_i   column sense, active-low, asynchronous
//   key_row_o   row drive, active-low, one row low at a time
//   entry_value_o  value being typed (0..99999999)
//   data_out_o  value committed by Enter
//   data_valid_o   one-cycle pulse when data_out_o updates
//   key_code_o  code of the last accepted key
//   key_pulse_o one-cycle pulse per accepted key
module keypad_num_entry #(
  parameter int          SCAN_DIV      = 5000,
  parameter int          DEBOUNCE_CNT  = 200000,
  parameter logic [27:0] DEFAULT_VALUE = 28'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_col_i,
  output logic [3:0]  key_row_o,
  output logic [27:0] entry_value_o,
  output logic [27:0] data_out_o,
  output logic        data_valid_o,
  output logic [3:0]  key_code_o,
  output logic        key_pulse_o
);
  typedef enum logic [1:0] {SCAN, DEB_PRESS, HOLD, DEB_REL} state_t;
  // 4-bit key codes indexed by {row, col}, entry 0 in the low nibble
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  state_t      state_q, state_d;
  logic [3:0]  col_m_q, col_s_q, lat_q, lat_d;
  logic [1:0]  row_q, row_d, col_idx;
  logic [31:0] cnt_q, cnt_d, prod;
  logic [27:0] entry_q, entry_d, dout_q, dout_d;
  logic [3:0]  dcnt_q, dcnt_d, code_q, code_d, code, inv;
  logic        fresh_q, fresh_d, dv_q, dv_d, kp_q, kp_d, acc, one_low, last;
  assign inv     = ~col_s_q;
  // exactly one column pulled low
  assign one_low = (inv != 4'd0) && ((inv & (inv - 4'd1)) == 4'd0);
  assign last    = cnt_q == DEBOUNCE_CNT - 1;
  assign col_idx = !lat_q[0] ? 2'd0 : !lat_q[1] ? 2'd1 : !lat_q[2] ? 2'd2 : 2'd3;
  assign code    = KEYMAP[{row_q, col_idx, 2'b00} +: 4];
  // 8-digit cap keeps entry below 2^27, so the truncated product never overflows
  assign prod    = {4'd0, entry_q} * 32'd10 + {28'd0, code};
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    acc     = 1'b0;
    case (state_q)
      SCAN: if (cnt_q == SCAN_DIV - 1) begin
        cnt_d = '0;
        if (one_low) begin
          lat_d   = col_s_q;
          state_d = DEB_PRESS;
        end else row_d = row_q + 2'd1;
      end else cnt_d = cnt_q + 32'd1;
      DEB_PRESS: if (col_s_q != lat_q) begin
        state_d = SCAN;
        cnt_d   = '0;
      end else if (last) begin
        acc     = 1'b1;
        state_d = HOLD;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 32'd1;
      HOLD: if (col_s_q == 4'hF) begin
        state_d = DEB_REL;
        cnt_d   = '0;
      end
      default: if (col_s_q != 4'hF) begin
        state_d = HOLD;
        cnt_d   = '0;
      end else if (last) begin
        state_d = SCAN;
        row_d   = row_q + 2'd1;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 32'd1;
    endcase
  end
  always_comb begin
    entry_d = entry_q;
    dcnt_d  = dcnt_q;
    fresh_d = fresh_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    kp_d    = acc;
    code_d  = acc ? code : code_q;
    if (acc) begin
      if (code <= 4'd9) begin
        if (fresh_q) begin
          entry_d = {24'd0, code};
          dcnt_d  = 4'd1;
          fresh_d = 1'b0;
        end else if (dcnt_q < 4'd8) begin
          entry_d = prod[27:0];
          dcnt_d  = dcnt_q + 4'd1;
        end
      end else if (code == 4'd13) begin
        entry_d = entry_q / 28'd10;
        dcnt_d  = dcnt_q - {3'd0, dcnt_q != 4'd0};
        fresh_d = 1'b0;
      end else if (code == 4'd14) begin
        entry_d = '0;
        dcnt_d  = '0;
        fresh_d = 1'b0;
      end else if (code == 4'd15) begin
        dout_d  = entry_q;
        dv_d    = 1'b1;
        fresh_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SCAN;
      col_m_q <= 4'hF;
      col_s_q <= 4'hF;
      lat_q   <= 4'hF;
      row_q   <= '0;
      cnt_q   <= '0;
      entry_q <= '0;
      dout_q  <= DEFAULT_VALUE;
      dcnt_q  <= '0;
      code_q  <= '0;
      fresh_q <= 1'b0;
      dv_q    <= 1'b0;
      kp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_m_q <= key_col_i;
      col_s_q <= col_m_q;
      lat_q   <= lat_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      dout_q  <= dout_d;
      dcnt_q  <= dcnt_d;
      code_q  <= code_d;
      fresh_q <= fresh_d;
      dv_q    <= dv_d;
      kp_q    <= kp_d;
    end
  end
  assign key_row_o     = ~(4'b0001 << row_q);
  assign entry_value_o = entry_q;
  assign data_out_o    = dout_q;
  assign data_valid_o  = dv_q;
  assign key_code_o    = code_q;
  assign key_pulse_o   = kp_q;
endmodule
